// File: rtl/golden_checker_pkg.sv
// Shared types, mailbox defaults and compare helpers for the golden result checker.
package golden_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } chk_state_e;

    localparam logic [15:0] DEF_END_ADDR = 16'h3fff;
    localparam logic [31:0] DEF_END_CODE = 32'hFFFF_FFFF;

    // Helpers work on a fixed wide operand; callers zero-extend (DATA_W, CNT_W <= 64).
    localparam int HELPER_W = 64;

    function automatic logic masked_mismatch(input logic [HELPER_W-1:0] act_w,
                                             input logic [HELPER_W-1:0] gold_w,
                                             input logic [HELPER_W-1:0] mask_w);
        return ((act_w ^ gold_w) & mask_w) != '0;
    endfunction

    function automatic logic [HELPER_W-1:0] sat_inc(input logic [HELPER_W-1:0] cnt,
                                                    input logic [HELPER_W-1:0] max_val);
        return (cnt == max_val) ? cnt : cnt + HELPER_W'(1);
    endfunction

endpackage

// File: rtl/golden_checker_lane.sv
// One compare lane: consumes act/exp pairs, counts masked mismatches, records first failure.
module golden_checker_lane
    import golden_checker_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              run,
    input  logic              en,
    input  logic [LEN_W-1:0]  len_r,
    input  logic [DATA_W-1:0] mask_r,
    input  logic              act_valid,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] act_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic              fire,
    output logic              lane_done,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [LEN_W-1:0]  first_err_idx,
    output logic              first_err_vld
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_nxt;
    logic             mismatch;

    assign idx_nxt  = idx + LEN_W'(1);
    assign fire     = run & en & (idx < len_r) & act_valid & exp_valid;
    assign mismatch = masked_mismatch(HELPER_W'(act_data), HELPER_W'(exp_data), HELPER_W'(mask_r));

    // Completion looks ahead through this cycle's fire so the FSM can leave RUN on the last edge.
    assign lane_done = ~en | (fire ? (idx_nxt == len_r) : (idx == len_r));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (clear) begin
            idx           <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (fire) begin
            idx <= idx_nxt;
            if (mismatch) begin
                err_cnt <= CNT_W'(sat_inc(HELPER_W'(err_cnt), HELPER_W'(CNT_MAX)));
                if (!first_err_vld) begin
                    first_err_idx <= idx;
                    first_err_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/golden_checker.sv
// Multi-lane golden compare checker with run timeout and end-of-simulation mailbox snoop.
// Handshake: act_ready/exp_ready assert only when the lane fires, and may depend on valid;
// a word pair is consumed on any edge where both valids and the readies are high.
module golden_checker
    import golden_checker_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                NUM_CH   = 2,
    parameter int                LEN_W    = 16,
    parameter int                CNT_W    = 16,
    parameter int                TO_W     = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(DEF_END_ADDR),
    parameter logic [DATA_W-1:0] END_CODE = DATA_W'(DEF_END_CODE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [DATA_W-1:0]        mask,
    input  logic [TO_W-1:0]          timeout,
    input  logic [NUM_CH-1:0]        act_valid,
    input  logic [NUM_CH-1:0]        exp_valid,
    input  logic [NUM_CH*DATA_W-1:0] act_data,
    input  logic [NUM_CH*DATA_W-1:0] exp_data,
    output logic [NUM_CH-1:0]        act_ready,
    output logic [NUM_CH-1:0]        exp_ready,
    input  logic                     snoop_we,
    input  logic [ADDR_W-1:0]        snoop_addr,
    input  logic [DATA_W-1:0]        snoop_data,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out,
    output logic                     pass,
    output logic                     sim_end,
    output logic [NUM_CH*CNT_W-1:0]  err_cnt,
    output logic [NUM_CH*LEN_W-1:0]  first_err_idx,
    output logic [NUM_CH-1:0]        first_err_vld,
    output logic [1:0]               dbg_state
);

    chk_state_e        state, state_nxt;
    logic [LEN_W-1:0]  len_r;
    logic [NUM_CH-1:0] ch_en_r;
    logic [DATA_W-1:0] mask_r;
    logic [TO_W-1:0]   timeout_r;
    logic [TO_W-1:0]   cyc_cnt;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] lane_done;
    logic [NUM_CH-1:0] lane_clean;
    logic              start_acc;
    logic              run;
    logic              all_done;
    logic              to_hit;

    assign start_acc = start & (state != ST_RUN);
    assign run       = (state == ST_RUN);
    assign all_done  = &lane_done;
    assign to_hit    = (timeout_r != '0) && (cyc_cnt == timeout_r - TO_W'(1));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        golden_checker_lane #(
            .DATA_W (DATA_W),
            .LEN_W  (LEN_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .clear         (start_acc),
            .run           (run),
            .en            (ch_en_r[c]),
            .len_r         (len_r),
            .mask_r        (mask_r),
            .act_valid     (act_valid[c]),
            .exp_valid     (exp_valid[c]),
            .act_data      (act_data[c*DATA_W +: DATA_W]),
            .exp_data      (exp_data[c*DATA_W +: DATA_W]),
            .fire          (fire[c]),
            .lane_done     (lane_done[c]),
            .err_cnt       (err_cnt[c*CNT_W +: CNT_W]),
            .first_err_idx (first_err_idx[c*LEN_W +: LEN_W]),
            .first_err_vld (first_err_vld[c])
        );
        assign lane_clean[c] = ~ch_en_r[c] | (err_cnt[c*CNT_W +: CNT_W] == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (all_done)    state_nxt = ST_DONE;
                else if (to_hit) state_nxt = ST_TIMEOUT;
            end
            default: begin
                if (start_acc)
                    state_nxt = ((ch_en == '0) || (len == '0)) ? ST_DONE : ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            len_r     <= '0;
            ch_en_r   <= '0;
            mask_r    <= '0;
            timeout_r <= '0;
            cyc_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                len_r     <= len;
                ch_en_r   <= ch_en;
                mask_r    <= mask;
                timeout_r <= timeout;
                cyc_cnt   <= '0;
            end else if (run) begin
                cyc_cnt <= cyc_cnt + TO_W'(1);
            end
        end
    end

    // Mailbox match is sticky across runs; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sim_end <= 1'b0;
        else if (snoop_we && (snoop_addr == END_ADDR) && (snoop_data == END_CODE))
            sim_end <= 1'b1;
    end

    assign act_ready = fire;
    assign exp_ready = fire;
    assign busy      = run;
    assign done      = (state == ST_DONE);
    assign timed_out = (state == ST_TIMEOUT);
    assign pass      = done & (&lane_clean);
    assign dbg_state = state;

endmodule
